updown_counter_mod: RTL and testbench

//  Parametrised up/down counter: next generation of the 8-bit lab counter.

---
 rtl/updown_counter_mod_pkg.sv | 17 +
 rtl/updown_counter_mod_clk_en_prescaler.sv | 46 ++++
 rtl/updown_counter_mod.sv | 102 ++++++++++
 tb/tb_updown_counter_mod.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/updown_counter_mod_pkg.sv
// ============================================================================
// Module : updown_counter_mod_pkg
// Brief  : Shared direction/mode encodings for counter-based blocks.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package updown_counter_mod_pkg;

  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DN    = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage : updown_counter_mod_pkg

`default_nettype wire

// File: rtl/updown_counter_mod_clk_en_prescaler.sv
// ============================================================================
// Module : clk_en_prescaler
// Brief  : Divides enabled clocks by PRESCALE and emits a one-cycle tick.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_en_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // For PRESCALE=1 the counter sits at 0 == C_LAST, so tick simply follows en.
  assign tick = en && (cnt_q == C_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : clk_en_prescaler

`default_nettype wire

// File: rtl/updown_counter_mod.sv
// ============================================================================
// Module : updown_counter_mod
// Brief  : Parametrised up/down counter with modulus, wrap/saturate, prescaler.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_counter_mod
  import updown_counter_mod_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = (1 << WIDTH) - 1,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap_evt,
  output logic             sat_evt
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX_VAL);

  logic             tick;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] q_q,    q_d;
  logic             wrap_q, wrap_d;
  logic             sat_q,  sat_d;

  clk_en_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .en      (en),
    .tick    (tick)
  );

  assign at_max  = (q_q == C_MAX);
  assign at_zero = (q_q == '0);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    sat_d  = 1'b0;
    if (clr) begin
      q_d = '0;
    end else if (LD) begin
      q_d = (D > C_MAX) ? C_MAX : D;
    end else if (tick) begin
      // Bounds are tested before the add/sub, so no carry bit is needed.
      if (up_dn == DIR_UP) begin
        if (!at_max) begin
          q_d = q_q + 1'b1;
        end else if (sat == MODE_SAT) begin
          sat_d = 1'b1;
        end else begin
          q_d    = '0;
          wrap_d = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          q_d = q_q - 1'b1;
        end else if (sat == MODE_SAT) begin
          sat_d = 1'b1;
        end else begin
          q_d    = C_MAX;
          wrap_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign Q        = q_q;
  assign wrap_evt = wrap_q;
  assign sat_evt  = sat_q;
  assign tc       = ((up_dn == DIR_UP) && at_max) || ((up_dn == DIR_DN) && at_zero);

endmodule : updown_counter_mod

`default_nettype wire

// File: tb/tb_updown_counter_mod.sv
// ============================================================================
// Module : tb_updown_counter_mod
// Brief  : Vector table, corner sequences and random run against a model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_updown_counter_mod;

  localparam int MAXV = 9;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clr = 1'b0, ld = 1'b0, en = 1'b0, up_dn = 1'b0, sat = 1'b0;
  logic [7:0] d = '0;
  logic [7:0] q0, q1;
  logic       tc0, tc1, wr0, wr1, st0, st1;

  int vectors = 0;
  int miscompares = 0;

  // reference state: [0] PRESCALE=1 instance, [1] PRESCALE=4 instance
  int  m_q[2];
  int  m_pre[2];
  bit  m_wr[2];
  bit  m_st[2];
  int  m_ps[2] = '{1, 4};

  always #5 clk = ~clk;

  updown_counter_mod #(.WIDTH(8), .MAX_VAL(MAXV), .PRESCALE(1)) u0 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .LD(ld), .D(d), .en(en),
    .up_dn(up_dn), .sat(sat), .Q(q0), .tc(tc0), .wrap_evt(wr0), .sat_evt(st0));

  updown_counter_mod #(.WIDTH(8), .MAX_VAL(MAXV), .PRESCALE(4)) u1 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .LD(ld), .D(d), .en(en),
    .up_dn(up_dn), .sat(sat), .Q(q1), .tc(tc1), .wrap_evt(wr1), .sat_evt(st1));

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_q[i] = 0; m_pre[i] = 0; m_wr[i] = 0; m_st[i] = 0;
    end
  endtask

  function automatic bit model_tc(input int q);
    return (!up_dn && q == MAXV) || (up_dn && q == 0);
  endfunction

  // Advance the model by one edge using the current inputs, then take the edge.
  task automatic edge_step();
    bit tk;
    for (int i = 0; i < 2; i++) begin
      m_wr[i] = 0; m_st[i] = 0;
      if (clr) begin
        m_q[i] = 0; m_pre[i] = 0;
      end else begin
        tk = en && (m_pre[i] == m_ps[i] - 1);
        if (en) m_pre[i] = (m_pre[i] + 1) % m_ps[i];
        if (ld) begin
          m_q[i] = (int'(d) > MAXV) ? MAXV : int'(d);
        end else if (tk) begin
          if (!up_dn) begin
            if (m_q[i] == MAXV && sat) m_st[i] = 1;
            else begin m_wr[i] = (m_q[i] == MAXV); m_q[i] = (m_q[i] + 1) % (MAXV + 1); end
          end else begin
            if (m_q[i] == 0 && sat) m_st[i] = 1;
            else begin m_wr[i] = (m_q[i] == 0); m_q[i] = (m_q[i] + MAXV) % (MAXV + 1); end
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit c, input bit l, input int dv, input bit e, input bit u, input bit s);
    clr = c; ld = l; d = 8'(dv); en = e; up_dn = u; sat = s;
  endtask

  typedef struct {
    bit clr; bit ld; int d; bit en; bit up_dn; bit sat;
    int q; bit tc; bit wr; bit st;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // counting up through the modulus with wrap
    for (int i = 1; i <= 10; i++)
      tbl.push_back('{0, 0, 0, 1, 0, 0, i % 10, (i == 9), (i == 10), 0});
    // down with saturation from 1
    tbl.push_back('{0, 1, 1, 0, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 1, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 1, 0, 1, 0, 1});
    tbl.push_back('{0, 0, 0, 1, 1, 1, 0, 1, 0, 1});
    // load clamp, clr beats LD, LD beats step
    tbl.push_back('{0, 1, 200, 0, 0, 0, 9, 1, 0, 0});
    tbl.push_back('{1, 1, 7, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 4, 1, 0, 0, 4, 0, 0, 0});
    // down wrap from 0
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 9, 0, 1, 0});

    model_reset();
    #12;
    check("reset_Q", q0, 0);
    check("reset_wrap", wr0, 0);
    check("reset_sat", st0, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      set_in(tbl[i].clr, tbl[i].ld, tbl[i].d, tbl[i].en, tbl[i].up_dn, tbl[i].sat);
      edge_step();
      check($sformatf("tbl%0d_Q", i), q0, tbl[i].q);
      check($sformatf("tbl%0d_tc", i), tc0, tbl[i].tc);
      check($sformatf("tbl%0d_wrap", i), wr0, tbl[i].wr);
      check($sformatf("tbl%0d_sat", i), st0, tbl[i].st);
    end

    // tc follows up_dn without a clock edge (Q=9 here)
    set_in(0, 0, 0, 0, 0, 0);
    #1; check("tc_up_at9", tc0, 1);
    up_dn = 1'b1;
    #1; check("tc_dn_at9", tc0, 0);
    check("wrap_still_high", wr0, 1);

    // async reset mid-cycle clears Q and pending flag
    reset_n = 1'b0;
    #1;
    check("async_rst_Q", q0, 0);
    check("async_rst_wrap", wr0, 0);
    model_reset();
    #1 reset_n = 1'b1;

    // async reset at Q=5
    set_in(0, 1, 5, 0, 0, 0);
    edge_step();
    check("ld5_Q", q0, 5);
    set_in(0, 0, 0, 1, 0, 0);
    #2 reset_n = 1'b0;
    #1 check("async_rst_at5_Q", q0, 0);
    model_reset();
    #1 reset_n = 1'b1;

    // PRESCALE=4: steps every 4th enabled edge, en gaps delay by exactly that
    set_in(1, 0, 0, 0, 0, 0);
    edge_step();
    set_in(0, 0, 0, 1, 0, 0);
    for (int e = 1; e <= 14; e++) begin
      en = !(e == 11 || e == 12);
      edge_step();
      check($sformatf("ps4_edge%0d_Q", e), q1, (e < 4) ? 0 : (e < 8) ? 1 : (e < 14) ? 2 : 3);
    end

    // random run against the model, both instances
    for (int n = 0; n < 600; n++) begin
      set_in(($urandom % 25) == 0, ($urandom % 12) == 0, int'($urandom % 256),
             ($urandom % 4) != 0, ($urandom % 8) < 3 ? ~up_dn : up_dn, $urandom % 2);
      edge_step();
      check($sformatf("rnd%0d_Q0", n), q0, m_q[0]);
      check($sformatf("rnd%0d_tc0", n), tc0, model_tc(m_q[0]));
      check($sformatf("rnd%0d_wr0", n), wr0, m_wr[0]);
      check($sformatf("rnd%0d_st0", n), st0, m_st[0]);
      check($sformatf("rnd%0d_Q1", n), q1, m_q[1]);
      check($sformatf("rnd%0d_tc1", n), tc1, model_tc(m_q[1]));
      check($sformatf("rnd%0d_wr1", n), wr1, m_wr[1]);
      check($sformatf("rnd%0d_st1", n), st1, m_st[1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_updown_counter_mod

`default_nettype wire
